led_pattern_gen: RTL and testbench

//  Parametrised N-channel LED pattern generator; next generation of the fixed 4-LED flasher.

---
 rtl/led_pattern_gen.sv | 137 +++++++++++++
 tb/tb_led_pattern_gen.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// N-channel LED pattern generator (off / solid / blink / chase) with step strobe.
// Define LED_PWM_EN to build the 16-level duty-cycle brightness gate on the LED outputs.
module led_pattern_gen #(
  parameter int unsigned N_LED       = 4,
  parameter int unsigned TICK_CYCLES = 5_000_000,
  parameter int unsigned RATE_W      = 4
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [RATE_W-1:0] rate,
  input  logic              dir,
  input  logic [3:0]        duty,
  output logic [N_LED-1:0]  led,
  output logic              step
);

  localparam int unsigned     TICK_W    = $clog2(TICK_CYCLES);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
  localparam logic [1:0]      MODE_OFF   = 2'd0;
  localparam logic [1:0]      MODE_SOLID = 2'd1;
  localparam logic [1:0]      MODE_BLINK = 2'd2;
  localparam logic [1:0]      MODE_CHASE = 2'd3;
  localparam logic [N_LED-1:0] PAT_LSB  = N_LED'(1);
  localparam logic [N_LED-1:0] PAT_MSB  = {1'b1, {(N_LED-1){1'b0}}};

  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [RATE_W-1:0] step_cnt_q, step_cnt_d;
  logic              phase_q, phase_d;
  logic [N_LED-1:0]  pat_q, pat_d;
  logic [1:0]        mode_q;
  logic              en_q;
  logic [N_LED-1:0]  led_q, led_d;
  logic              step_q, step_d;

  logic              restart_c;
  logic              tick_c;
  logic              step_ev_c;
  logic [N_LED-1:0]  pat_init_c;
  logic [N_LED-1:0]  pat_rot_c;
  logic [N_LED-1:0]  pat_led_c;

  // A mode change or a fresh enable restarts counters and reloads the pattern.
  assign restart_c  = en && ((mode != mode_q) || !en_q);
  assign tick_c     = (tick_cnt_q == TICK_LAST);
  assign step_ev_c  = en && !restart_c && tick_c && (step_cnt_q >= rate);
  assign pat_init_c = dir ? PAT_MSB : PAT_LSB;
  assign pat_rot_c  = dir ? {pat_q[0], pat_q[N_LED-1:1]}
                          : {pat_q[N_LED-2:0], pat_q[N_LED-1]};

  always_comb begin
    tick_cnt_d = '0;
    step_cnt_d = '0;
    phase_d    = 1'b0;
    pat_d      = '0;
    step_d     = 1'b0;
    if (en && !restart_c) begin
      tick_cnt_d = tick_c ? '0 : tick_cnt_q + TICK_W'(1);
      if (step_ev_c)   step_cnt_d = '0;
      else if (tick_c) step_cnt_d = step_cnt_q + RATE_W'(1);
      else             step_cnt_d = step_cnt_q;
    end
    if (en) begin
      case (mode)
        MODE_BLINK: begin
          phase_d = restart_c ? 1'b1 : (phase_q ^ step_ev_c);
          step_d  = step_ev_c;
        end
        MODE_CHASE: begin
          if (restart_c)      pat_d = pat_init_c;
          else if (step_ev_c) pat_d = pat_rot_c;
          else                pat_d = pat_q;
          step_d = step_ev_c;
        end
        default: ;
      endcase
    end
  end

  // LED image follows the pattern state being loaded on this edge.
  always_comb begin
    pat_led_c = '0;
    if (en) begin
      case (mode)
        MODE_OFF:   pat_led_c = '0;
        MODE_SOLID: pat_led_c = '1;
        MODE_BLINK: pat_led_c = {N_LED{phase_d}};
        MODE_CHASE: pat_led_c = pat_d;
        default:    pat_led_c = '0;
      endcase
    end
  end

`ifdef LED_PWM_EN
  logic [3:0] pwm_cnt_q, pwm_cnt_d;

  assign pwm_cnt_d = en ? pwm_cnt_q + 4'd1 : 4'd0;
  assign led_d     = pat_led_c & {N_LED{pwm_cnt_q <= duty}};

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) pwm_cnt_q <= 4'd0;
    else     pwm_cnt_q <= pwm_cnt_d;
  end
`else
  logic unused_duty_c;

  assign unused_duty_c = ^duty;
  assign led_d         = pat_led_c;
`endif

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      tick_cnt_q <= '0;
      step_cnt_q <= '0;
      phase_q    <= 1'b0;
      pat_q      <= '0;
      mode_q     <= 2'd0;
      en_q       <= 1'b0;
      led_q      <= '0;
      step_q     <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      step_cnt_q <= step_cnt_d;
      phase_q    <= phase_d;
      pat_q      <= pat_d;
      mode_q     <= mode;
      en_q       <= en;
      led_q      <= led_d;
      step_q     <= step_d;
    end
  end

  assign led  = led_q;
  assign step = step_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen; reference model counts ticks and steps arithmetically.
module tb_led_pattern_gen;

  localparam int N  = 4;
  localparam int TC = 4;

  logic       sys_clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [3:0] rate;
  logic       dir;
  logic [3:0] duty;
  logic [3:0] led;
  logic       step;

  int n_tests = 0;
  int n_fail  = 0;

  int         m_k, m_t, m_steps, m_pos, m_md;
  logic [3:0] e_led;
  logic       e_step;

  led_pattern_gen #(.N_LED(N), .TICK_CYCLES(TC), .RATE_W(4)) dut (
    .sys_clk(sys_clk), .rst(rst), .en(en), .mode(mode), .rate(rate),
    .dir(dir), .duty(duty), .led(led), .step(step)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [3:0] model_led();
    case (m_md)
      1:       return 4'hF;
      2:       return (m_steps % 2 == 0) ? 4'hF : 4'h0;
      3:       return 4'(1 << m_pos);
      default: return 4'h0;
    endcase
  endfunction

  task automatic model_restart(input int md, input logic d);
    m_md = md; m_k = 0; m_t = 0; m_steps = 0;
    m_pos = d ? N - 1 : 0;
    e_step = 1'b0;
    e_led = model_led();
  endtask

  // One clock edge: a tick every TC cycles, a step once rate+1 ticks have gathered.
  task automatic model_edge(input int rt, input logic d);
    m_k++;
    e_step = 1'b0;
    if (m_k % TC == 0) begin
      m_t++;
      if (m_t >= rt + 1) begin
        m_t = 0;
        m_steps++;
        m_pos = d ? (m_pos + N - 1) % N : (m_pos + 1) % N;
        e_step = (m_md >= 2);
      end
    end
    e_led = model_led();
  endtask

  task automatic restart_en(input int md, input int rt, input logic d);
    en = 1'b0;
    @(negedge sys_clk);
    mode = 2'(md); rate = 4'(rt); dir = d; en = 1'b1;
    model_restart(md, d);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; mode = 2'd0; rate = 4'd0; dir = 1'b0; duty = 4'd15;
    @(negedge sys_clk);
    n_tests++;
    if (led !== 4'h0 || step !== 1'b0) begin
      n_fail++; $display("FAIL reset_hold led=%b step=%b expected 0000/0", led, step);
    end
    rst = 1'b0;
    restart_en(2, 0, 1'b0);
    for (int j = 0; j < 3; j++) begin
      @(negedge sys_clk);
      n_tests++;
      if (led !== e_led || step !== e_step) begin
        n_fail++; $display("FAIL reset_pre j=%0d led=%b step=%b expected %b/%b", j, led, step, e_led, e_step);
      end
      model_edge(rate, dir);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if (led !== 4'h0 || step !== 1'b0) begin
      n_fail++; $display("FAIL reset_async led=%b step=%b expected 0000/0", led, step);
    end
    @(negedge sys_clk);
    rst = 1'b0; en = 1'b0;
    for (int j = 0; j < 4; j++) begin
      @(negedge sys_clk);
      n_tests++;
      if (led !== 4'h0 || step !== 1'b0) begin
        n_fail++; $display("FAIL reset_release j=%0d led=%b step=%b expected 0000/0", j, led, step);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      restart_en(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      for (int j = 0; j < 40; j++) begin
        @(negedge sys_clk);
        n_tests++;
        if (led !== e_led || step !== e_step) begin
          n_fail++; $display("FAIL random it=%0d j=%0d mode=%0d led=%b step=%b expected %b/%b",
                             it, j, m_md, led, step, e_led, e_step);
        end
        if ($urandom_range(0, 15) == 0) rate = 4'($urandom_range(0, 2));
        if ($urandom_range(0, 15) == 0) dir = ~dir;
        model_edge(rate, dir);
      end
    end
  endtask

  task automatic test_dir_flip();
    logic flipped = 1'b0;
    restart_en(3, 1, 1'b0);
    for (int j = 0; j < 60; j++) begin
      @(negedge sys_clk);
      n_tests++;
      if (led !== e_led || step !== e_step) begin
        n_fail++; $display("FAIL dir_flip j=%0d led=%b step=%b expected %b/%b", j, led, step, e_led, e_step);
      end
      if (!flipped && e_led == 4'b0100) begin
        dir = 1'b1; flipped = 1'b1;
      end
      model_edge(rate, dir);
    end
  endtask

  task automatic test_mode_change();
    restart_en(2, 1, 1'b0);
    for (int j = 0; j < 30; j++) begin
      @(negedge sys_clk);
      n_tests++;
      if (led !== e_led || step !== e_step) begin
        n_fail++; $display("FAIL mode_change j=%0d led=%b step=%b expected %b/%b", j, led, step, e_led, e_step);
      end
      if (j == 5) begin
        mode = 2'd3; dir = 1'b0;
        model_restart(3, 1'b0);
      end else begin
        model_edge(rate, dir);
      end
    end
  endtask

  task automatic test_solid_off();
    restart_en(1, 0, 1'b0);
    for (int j = 0; j < 12; j++) begin
      @(negedge sys_clk);
      n_tests++;
      if (led !== 4'hF || step !== 1'b0) begin
        n_fail++; $display("FAIL solid j=%0d led=%b step=%b expected 1111/0", j, led, step);
      end
    end
    en = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge sys_clk);
      n_tests++;
      if (led !== 4'h0 || step !== 1'b0) begin
        n_fail++; $display("FAIL en_drop j=%0d led=%b step=%b expected 0000/0", j, led, step);
      end
    end
    mode = 2'd2; en = 1'b1;
    model_restart(2, dir);
    for (int j = 0; j < 14; j++) begin
      @(negedge sys_clk);
      n_tests++;
      if (led !== e_led || step !== e_step) begin
        n_fail++; $display("FAIL re_enable j=%0d led=%b step=%b expected %b/%b", j, led, step, e_led, e_step);
      end
      model_edge(rate, dir);
    end
    mode = 2'd0;
    for (int j = 0; j < 10; j++) begin
      @(negedge sys_clk);
      n_tests++;
      if (led !== 4'h0 || step !== 1'b0) begin
        n_fail++; $display("FAIL mode_off j=%0d led=%b step=%b expected 0000/0", j, led, step);
      end
    end
  endtask

  task automatic test_rate_change();
    restart_en(2, 3, 1'b0);
    for (int j = 0; j < 50; j++) begin
      @(negedge sys_clk);
      n_tests++;
      if (led !== e_led || step !== e_step) begin
        n_fail++; $display("FAIL rate_change j=%0d led=%b step=%b expected %b/%b", j, led, step, e_led, e_step);
      end
      if (j == 9)  rate = 4'd0;
      if (j == 20) rate = 4'd2;
      model_edge(rate, dir);
    end
  endtask

`ifdef LED_PWM_EN
  task automatic test_pwm();
    int lit = 0;
    duty = 4'd3;
    restart_en(1, 0, 1'b0);
    for (int j = 0; j < 32; j++) begin
      @(negedge sys_clk);
      if (led == 4'hF) lit++;
      else if (led != 4'h0) begin
        n_tests++; n_fail++; $display("FAIL pwm_partial j=%0d led=%b expected 0000 or 1111", j, led);
      end
    end
    n_tests++;
    if (lit != 8) begin
      n_fail++; $display("FAIL pwm_duty3 lit_cycles=%0d expected 8", lit);
    end
    duty = 4'd15;
    @(negedge sys_clk);
    for (int j = 0; j < 16; j++) begin
      @(negedge sys_clk);
      n_tests++;
      if (led !== 4'hF) begin
        n_fail++; $display("FAIL pwm_duty15 j=%0d led=%b expected 1111", j, led);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_random();
    test_dir_flip();
    test_mode_change();
    test_solid_off();
    test_rate_change();
`ifdef LED_PWM_EN
    test_pwm();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
